// File: rtl/lwsw_enc_pkg.sv
// Shared constants, FSM state type and the alignment helper for the lwsw symbol encoder.
package lwsw_enc_pkg;

    localparam logic [1:0] KIND_LOAD  = 2'b01;
    localparam logic [1:0] KIND_STORE = 2'b10;
    localparam logic [7:0] SYM_IDLE   = 8'h00;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        DRAIN  = 2'b10
    } state_e;

    // Natural alignment check on the low three address bits.
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic mis;
        case (size)
            SIZE_BYTE:  mis = 1'b0;
            SIZE_HALF:  mis = addr_lo[0];
            SIZE_WORD:  mis = |addr_lo[1:0];
            SIZE_DWORD: mis = |addr_lo;
            default:    mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lwsw_sym_fifo.sv
// Two-write / one-read symbol FIFO; write port 0 lands ahead of write port 1.
// The caller guarantees writes never exceed the reported free space.
module lwsw_sym_fifo #(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr0_en,
    input  logic [7:0]       wr0_data,
    input  logic             wr1_en,
    input  logic [7:0]       wr1_data,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] free
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q + PTR_W'(wr0_en) + PTR_W'(wr1_en);
        rptr_d = rptr_q + PTR_W'(rd_en);
        level_d = level_q + LVL_W'(wr0_en) + LVL_W'(wr1_en) - LVL_W'(rd_en);
        if (wr0_en) begin
            mem_d[wptr_q] = wr0_data;
        end
        if (wr1_en) begin
            mem_d[wptr_q + PTR_W'(wr0_en)] = wr1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rptr_q];
    assign level   = level_q;
    // A same-cycle pop frees its slot for this cycle's writes.
    assign free    = LVL_W'(DEPTH) - level_q + LVL_W'(rd_en);

endmodule

// File: rtl/lwsw_symbol_encoder.sv
// Encodes retired loads/stores into 8-bit monitor symbols and streams them one per cycle.
// Build option LWSW_IDLE_SYMBOL_EN: emit SYM_IDLE with run=1 while ACTIVE and the FIFO is empty.
module lwsw_symbol_encoder
    import lwsw_enc_pkg::*;
#(
    parameter int NR_PORTS = 2,
    parameter int DEPTH    = 8,
    parameter int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_ovf,
    input  logic [NR_PORTS-1:0]   cm_valid,
    input  logic [NR_PORTS-1:0]   cm_is_load,
    input  logic [NR_PORTS-1:0]   cm_is_store,
    input  logic [2*NR_PORTS-1:0] cm_size,
    input  logic [3*NR_PORTS-1:0] cm_addr_lo,
    input  logic [NR_PORTS-1:0]   cm_exc,
    output logic [7:0]            symbols,
    output logic                  run,
    output logic                  overflow,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  busy
);

    state_e           state_q, state_d;
    logic [1:0]       seq_q, seq_d;
    logic [7:0]       symbols_q, symbols_d;
    logic             run_q, run_d;
    logic             overflow_q, overflow_d;

    logic             write_ok;
    logic             pop;
    logic             drop;
    logic [1:0]       elig;
    logic [1:0]       acc;
    logic [7:0]       sym0, sym1;
    logic [7:0]       rd_data;
    logic [LVL_W-1:0] level, free, level_after_pop;

    always_comb begin
        write_ok = (state_q == ACTIVE) && enable;
        pop      = (level != '0) && (state_q != IDLE);
        for (int p = 0; p < 2; p++) begin
            elig[p] = write_ok && cm_valid[p] && (cm_is_load[p] ^ cm_is_store[p]);
        end
        acc[0] = elig[0] && (free != '0);
        acc[1] = elig[1] && (free > LVL_W'(acc[0]));
        drop   = |(elig & ~acc);

        // Port 1 is younger: it takes the next sequence number when port 0 also retires.
        sym0 = {(cm_is_load[0] ? KIND_LOAD : KIND_STORE), cm_size[1:0], cm_exc[0],
                misaligned(cm_size[1:0], cm_addr_lo[2:0]), seq_q};
        sym1 = {(cm_is_load[1] ? KIND_LOAD : KIND_STORE), cm_size[3:2], cm_exc[1],
                misaligned(cm_size[3:2], cm_addr_lo[5:3]), seq_q + 2'(elig[0])};
        seq_d = seq_q + 2'(elig[0]) + 2'(elig[1]);

        overflow_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);

        symbols_d = symbols_q;
        run_d     = 1'b0;
        if (pop) begin
            symbols_d = rd_data;
            run_d     = 1'b1;
        end
`ifdef LWSW_IDLE_SYMBOL_EN
        else if (state_q == ACTIVE) begin
            symbols_d = SYM_IDLE;
            run_d     = 1'b1;
        end
`endif

        level_after_pop = level - LVL_W'(pop);
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!enable) state_d = (level_after_pop != '0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (enable) state_d = ACTIVE;
                else if (level_after_pop == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            seq_q      <= 2'b00;
            symbols_q  <= 8'h00;
            run_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_q      <= seq_d;
            symbols_q  <= symbols_d;
            run_q      <= run_d;
            overflow_q <= overflow_d;
        end
    end

    lwsw_sym_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr0_en   (acc[0]),
        .wr0_data (sym0),
        .wr1_en   (acc[1]),
        .wr1_data (sym1),
        .rd_en    (pop),
        .rd_data  (rd_data),
        .level    (level),
        .free     (free)
    );

    assign symbols    = symbols_q;
    assign run        = run_q;
    assign overflow   = overflow_q;
    assign fifo_level = level;
    assign busy       = (state_q != IDLE);

endmodule
